// File: rtl/cbd_pkg.sv
// rtl/cbd_pkg.sv - shared constants, legality checks and FSM encoding for the CBD sampler
package cbd_pkg;

    localparam int CBD_Q       = 3329;
    localparam int CBD_COEFF_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } cbd_state_e;

    function automatic bit cbd_eta_ok(input int eta);
        return (eta == 2) || (eta == 3);
    endfunction

    function automatic bit cbd_lanes_ok(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4);
    endfunction

endpackage

// File: rtl/cbd_sampler_if.sv
// rtl/cbd_sampler_if.sv - control, random-bit stream and dpram write port of the CBD sampler
interface cbd_sampler_if #(
    parameter int ETA     = 3,
    parameter int LANES   = 1,
    parameter int COEFF_W = 12,
    parameter int ADDR_W  = 10
);
    logic                       start;
    logic [ADDR_W-1:0]          base_addr;
    logic [2*ETA*LANES-1:0]     in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [LANES*COEFF_W-1:0]   wr_data;
    logic                       busy;
    logic                       done;

    modport master (
        output start, base_addr, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, base_addr, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/cbd_lane.sv
// rtl/cbd_lane.sv - one CBD coefficient: popcount difference reduced into [0, Q-1]
module cbd_lane #(
    parameter int ETA     = 3,
    parameter int Q       = 3329,
    parameter int COEFF_W = 12
) (
    input  logic [2*ETA-1:0]   x,
    output logic [COEFF_W-1:0] coeff
);
    logic [1:0] a;
    logic [1:0] b;

    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < ETA; i++) begin
            a = a + 2'(x[i]);
            b = b + 2'(x[ETA+i]);
        end
        // a == b lands in the first branch so zero never becomes Q
        if (a >= b) begin
            coeff = COEFF_W'(a - b);
        end else begin
            coeff = COEFF_W'(Q) - COEFF_W'(b - a);
        end
    end
endmodule

// File: rtl/cbd_sampler.sv
// rtl/cbd_sampler.sv - CBD sampler: streams random bits into one polynomial of dpram writes
module cbd_sampler
    import cbd_pkg::*;
#(
    parameter int ETA     = 3,
    parameter int LANES   = 1,
    parameter int N       = 256,
    parameter int Q       = CBD_Q,
    parameter int COEFF_W = CBD_COEFF_W,
    parameter int ADDR_W  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    cbd_sampler_if.slave  bus
);
    localparam int BEATS  = N / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (!cbd_eta_ok(ETA)) begin : g_bad_eta
        $error("cbd_sampler: ETA must be 2 or 3");
    end
    if (!cbd_lanes_ok(LANES)) begin : g_bad_lanes
        $error("cbd_sampler: LANES must be 1, 2 or 4");
    end
    if ((N % LANES) != 0) begin : g_bad_n
        $error("cbd_sampler: N must be a multiple of LANES");
    end

    cbd_state_e               state_q;
    cbd_state_e               state_d;
    logic [BEAT_W-1:0]        beat_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     wr_en_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [LANES*COEFF_W-1:0] wr_data_q;
    logic                     busy_q;
    logic                     done_q;
    logic [LANES*COEFF_W-1:0] coeffs;
    logic                     start_ok;
    logic                     accept;
    logic                     last_beat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cbd_lane #(
            .ETA     (ETA),
            .Q       (Q),
            .COEFF_W (COEFF_W)
        ) u_lane (
            .x     (bus.in_data[2*ETA*k +: 2*ETA]),
            .coeff (coeffs[COEFF_W*k +: COEFF_W])
        );
    end

    // The done cycle is already IDLE, so a start coinciding with done must be masked
    assign start_ok  = (state_q == ST_IDLE) && bus.start && !done_q;
    assign accept    = (state_q == ST_RUN) && bus.in_valid;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (accept && last_beat) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q    <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= accept;
            done_q  <= (state_q == ST_FLUSH);
            if (start_ok) begin
                addr_q <= bus.base_addr;
                beat_q <= '0;
                busy_q <= 1'b1;
            end
            if (state_q == ST_FLUSH) begin
                busy_q <= 1'b0;
            end
            if (accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= coeffs;
                addr_q    <= addr_q + 1'b1;
                beat_q    <= beat_q + 1'b1;
            end
        end
    end

    assign bus.in_ready = (state_q == ST_RUN);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_cbd_sampler.sv
// tb/tb_cbd_sampler.sv - scoreboard bench for cbd_sampler (ETA=3/LANES=1 and ETA=2/LANES=4)
module tb_cbd_sampler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [47:0] data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_b[$];

    cbd_sampler_if #(.ETA(3), .LANES(1), .COEFF_W(12), .ADDR_W(10)) a_if ();
    cbd_sampler_if #(.ETA(2), .LANES(4), .COEFF_W(12), .ADDR_W(10)) b_if ();

    cbd_sampler #(.ETA(3), .LANES(1), .N(256), .Q(3329), .COEFF_W(12), .ADDR_W(10)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    cbd_sampler #(.ETA(2), .LANES(4), .N(256), .Q(3329), .COEFF_W(12), .ADDR_W(10)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    function automatic int ref_coeff(input int eta, input int x);
        int a = 0;
        int b = 0;
        for (int i = 0; i < eta; i++) begin
            a += (x >> i) & 1;
            b += (x >> (i + eta)) & 1;
        end
        return (a - b + 3329) % 3329;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_if.wr_en !== 1'b0)    begin failures++; $display("FAIL reset_a_wr_en got=%b exp=0", a_if.wr_en); end
        checks++; if (a_if.wr_addr !== 10'd0) begin failures++; $display("FAIL reset_a_wr_addr got=%0d exp=0", a_if.wr_addr); end
        checks++; if (a_if.wr_data !== 12'd0) begin failures++; $display("FAIL reset_a_wr_data got=%0d exp=0", a_if.wr_data); end
        checks++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL reset_a_in_ready got=%b exp=0", a_if.in_ready); end
        checks++; if (a_if.busy !== 1'b0)     begin failures++; $display("FAIL reset_a_busy got=%b exp=0", a_if.busy); end
        checks++; if (a_if.done !== 1'b0)     begin failures++; $display("FAIL reset_a_done got=%b exp=0", a_if.done); end
        checks++; if (b_if.wr_en !== 1'b0)    begin failures++; $display("FAIL reset_b_wr_en got=%b exp=0", b_if.wr_en); end
        checks++; if (b_if.wr_data !== 48'd0) begin failures++; $display("FAIL reset_b_wr_data got=%h exp=0", b_if.wr_data); end
        checks++; if (b_if.in_ready !== 1'b0) begin failures++; $display("FAIL reset_b_in_ready got=%b exp=0", b_if.in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_valid();
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_if.in_data = 6'($urandom);
            @(negedge clk);
            checks++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready cyc=%0d got=%b exp=0", i, a_if.in_ready); end
            checks++; if (a_if.wr_en !== 1'b0)    begin failures++; $display("FAIL idle_wr_en cyc=%0d got=%b exp=0", i, a_if.wr_en); end
            checks++; if (a_if.busy !== 1'b0)     begin failures++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", i, a_if.busy); end
        end
        a_if.in_valid = 1'b0;
    endtask

    // Called at a negedge; frame on instance A. stop_at < 256 abandons the frame after that many beats.
    task automatic run_frame_a(input logic [9:0] base, input bit toggle, input bit spam,
                               input bit rnd, input int stop_at);
        int  beats = 0;
        int  cyc = 0;
        int  nwr = 0;
        bit  pend = 1'b0;
        bit  v;
        logic [5:0] d;
        wr_t e;
        a_if.start = 1'b1;
        a_if.base_addr = base;
        @(negedge clk);
        a_if.start = 1'b0;
        a_if.base_addr = ~base;
        checks++; if (a_if.busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", a_if.busy); end
        while ((beats < stop_at && beats < 256) || pend) begin
            checks++; if (a_if.in_ready !== (beats < 256)) begin failures++; $display("FAIL a_in_ready beat=%0d got=%b exp=%b", beats, a_if.in_ready, beats < 256); end
            checks++; if (a_if.wr_en !== pend) begin failures++; $display("FAIL a_wr_en beat=%0d got=%b exp=%b", beats, a_if.wr_en, pend); end
            checks++; if (a_if.done !== 1'b0 || a_if.busy !== 1'b1) begin failures++; $display("FAIL a_busy_done beat=%0d got=%b%b exp=10", beats, a_if.busy, a_if.done); end
            if (pend) begin
                nwr++;
                if (q_a.size() == 0) begin
                    checks++; failures++; $display("FAIL a_scoreboard_empty got=write exp=none");
                end else begin
                    e = q_a.pop_front();
                    checks++; if (a_if.wr_addr !== e.addr) begin failures++; $display("FAIL a_wr_addr got=%0d exp=%0d", a_if.wr_addr, e.addr); end
                    checks++; if (a_if.wr_data !== e.data[11:0]) begin failures++; $display("FAIL a_wr_data addr=%0d got=%0d exp=%0d", e.addr, a_if.wr_data, e.data[11:0]); end
                    if (!rnd && base == 10'd0 && (e.addr == 10'd7 || e.addr == 10'd56 || e.addr == 10'd63)) begin
                        checks++;
                        if (a_if.wr_data !== ((e.addr == 10'd7) ? 12'd3 : (e.addr == 10'd56) ? 12'd3326 : 12'd0)) begin
                            failures++; $display("FAIL a_known_coeff addr=%0d got=%0d", e.addr, a_if.wr_data);
                        end
                    end
                end
            end
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            d = rnd ? 6'($urandom) : 6'(beats);
            a_if.in_valid = v;
            a_if.in_data = d;
            a_if.start = spam && (beats == 10 || beats == 255);
            pend = v && beats < stop_at && beats < 256;
            if (pend) begin
                e.addr = base + 10'(beats);
                e.data = 48'(ref_coeff(3, int'(d)));
                q_a.push_back(e);
                beats++;
            end
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                checks++; failures++; $display("FAIL a_frame_timeout got=%0d beats exp=256", beats);
                break;
            end
        end
        a_if.in_valid = 1'b0;
        a_if.start = 1'b0;
        if (stop_at < 256) return;
        checks++; if (a_if.done !== 1'b1)  begin failures++; $display("FAIL a_done got=%b exp=1", a_if.done); end
        checks++; if (a_if.busy !== 1'b0)  begin failures++; $display("FAIL a_done_busy got=%b exp=0", a_if.busy); end
        checks++; if (a_if.wr_en !== 1'b0) begin failures++; $display("FAIL a_done_wr_en got=%b exp=0", a_if.wr_en); end
        a_if.start = spam;
        @(negedge clk);
        a_if.start = 1'b0;
        checks++; if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) begin failures++; $display("FAIL a_after_done got=busy%b done%b exp=00", a_if.busy, a_if.done); end
        checks++; if (nwr !== 256) begin failures++; $display("FAIL a_write_count got=%0d exp=256", nwr); end
        checks++; if (q_a.size() !== 0) begin failures++; $display("FAIL a_queue_left got=%0d exp=0", q_a.size()); end
    endtask

    task automatic test_full_frame();
        run_frame_a(10'd0, 1'b0, 1'b0, 1'b0, 256);
    endtask

    task automatic test_valid_gaps();
        run_frame_a(10'd100, 1'b1, 1'b0, 1'b1, 256);
    endtask

    task automatic test_start_ignore();
        run_frame_a(10'd3, 1'b0, 1'b1, 1'b0, 256);
        run_frame_a(10'd200, 1'b0, 1'b0, 1'b1, 256);
    endtask

    task automatic test_reset_mid();
        run_frame_a(10'd40, 1'b0, 1'b0, 1'b1, 100);
        rst_n = 1'b0;
        #1;
        checks++; if ({a_if.wr_en, a_if.busy, a_if.done, a_if.in_ready} !== 4'b0) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=0000", {a_if.wr_en, a_if.busy, a_if.done, a_if.in_ready}); end
        checks++; if (a_if.wr_addr !== 10'd0 || a_if.wr_data !== 12'd0) begin failures++; $display("FAIL rstmid_wr got=%0d/%0d exp=0/0", a_if.wr_addr, a_if.wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
        q_a.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (a_if.wr_en !== 1'b0 || a_if.done !== 1'b0) begin failures++; $display("FAIL rstmid_quiet cyc=%0d got=%b%b exp=00", i, a_if.wr_en, a_if.done); end
        end
        run_frame_a(10'd7, 1'b0, 1'b0, 1'b1, 256);
    endtask

    task automatic test_wrap_b();
        int  beats = 0;
        int  cyc = 0;
        int  nwr = 0;
        bit  pend = 1'b0;
        logic [15:0] d;
        wr_t e;
        b_if.start = 1'b1;
        b_if.base_addr = 10'd1020;
        @(negedge clk);
        b_if.start = 1'b0;
        while ((beats < 64 || pend) && cyc < 1000) begin
            checks++; if (b_if.in_ready !== (beats < 64)) begin failures++; $display("FAIL b_in_ready beat=%0d got=%b exp=%b", beats, b_if.in_ready, beats < 64); end
            checks++; if (b_if.wr_en !== pend) begin failures++; $display("FAIL b_wr_en beat=%0d got=%b exp=%b", beats, b_if.wr_en, pend); end
            if (pend) begin
                nwr++;
                e = q_b.pop_front();
                checks++; if (b_if.wr_addr !== e.addr) begin failures++; $display("FAIL b_wr_addr got=%0d exp=%0d", b_if.wr_addr, e.addr); end
                checks++; if (b_if.wr_data !== e.data) begin failures++; $display("FAIL b_wr_data addr=%0d got=%h exp=%h", e.addr, b_if.wr_data, e.data); end
                if (e.addr == 10'd1020) begin
                    checks++; if (b_if.wr_data !== 48'h002CFF000000) begin failures++; $display("FAIL b_known_lanes got=%h exp=002cff000000", b_if.wr_data); end
                end
            end
            if (beats < 64) begin
                d = (beats == 0) ? 16'h3CF0 : 16'($urandom);
                e.addr = 10'd1020 + 10'(beats);
                for (int k = 0; k < 4; k++) e.data[12*k +: 12] = 12'(ref_coeff(2, int'((d >> (4*k)) & 16'hF)));
                q_b.push_back(e);
                b_if.in_valid = 1'b1;
                b_if.in_data = d;
                beats++;
                pend = 1'b1;
            end else begin
                b_if.in_valid = 1'b0;
                pend = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++; if (b_if.done !== 1'b1 || b_if.busy !== 1'b0) begin failures++; $display("FAIL b_done got=busy%b done%b exp=busy0 done1", b_if.busy, b_if.done); end
        checks++; if (nwr !== 64) begin failures++; $display("FAIL b_write_count got=%0d exp=64", nwr); end
        @(negedge clk);
    endtask

    initial begin
        a_if.start = 1'b0; a_if.base_addr = '0; a_if.in_data = '0; a_if.in_valid = 1'b0;
        b_if.start = 1'b0; b_if.base_addr = '0; b_if.in_data = '0; b_if.in_valid = 1'b0;
        test_reset();
        test_idle_valid();
        test_full_frame();
        test_valid_gaps();
        test_start_ignore();
        test_reset_mid();
        test_wrap_b();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbd_sampler.md
Name: cbd_sampler

Overview:
Parametrised centred-binomial-distribution (CBD) sampler for the NTT datapath with modulus Q = 3329.
- Accepts a stream of uniform random bits and produces LANES coefficients per accepted beat.
- Each coefficient is (sum of ETA bits − sum of next ETA bits) mod Q.
- Writes one complete polynomial of N coefficients into the coefficient dpram over a simple write port: port A, word width LANES*COEFF_W.
- Successor to the fixed eta=3, single-write sampler. Adds ETA/LANES generality, a start/busy/done frame, a valid/ready input, auto-incrementing addresses and a corrected modular reduction.

Parameters:
ETA, 3, CBD parameter; legal values 2 or 3; each coefficient consumes 2*ETA input bits.
LANES, 1, coefficients produced per beat; legal 1, 2, 4.
N, 256, coefficients per polynomial; N % LANES == 0.
Q, 3329, modulus.
COEFF_W, 12, coefficient width.
ADDR_W, 10, dpram address width.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; begins a polynomial; ignored while busy.
base_addr  in  ADDR_W  first write address; latched on accepted start.
in_data  in  2*ETA*LANES  random bits; lane k uses bits [2*ETA*k +: 2*ETA].
in_valid  in  1  in_data valid.
in_ready  out  1  sampler accepts a beat this cycle.
wr_en  out  1  dpram write enable; drives ena and wea.
wr_addr  out  ADDR_W  dpram write address.
wr_data  out  LANES*COEFF_W  coefficients; lane k in [COEFF_W*k +: COEFF_W].
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset: every output is 0; FSM = IDLE; beat counter = 0.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: in_ready=0. On start=1: latch base_addr, clear beat counter, busy=1, go to RUN.
  - RUN: in_ready=1. A beat is accepted when in_valid && in_ready. On acceptance of beat N/LANES−1, go to FLUSH; in_ready drops in the next cycle.
  - FLUSH: single cycle in which the last write is presented. Next cycle: done=1, busy=0, state IDLE.
- Per-lane arithmetic on the 2*ETA bits x:
  - a = popcount(x[ETA−1:0]); b = popcount(x[2*ETA−1:ETA]); both 2 bits wide.
  - coeff = (a >= b) ? a − b : Q − (b − a). Range is [0, Q−1].
  - a == b must give 0, never Q.
- Latency: a beat accepted at edge t appears on wr_en/wr_addr/wr_data as registered outputs in the cycle after edge t, i.e. written at edge t+1. There are no other pipeline stages.
- Addressing: beat i writes address base_addr + i, modulo 2^ADDR_W; wrap-around is silent.
- wr_en is high only for cycles carrying an accepted beat. Gaps in in_valid produce gaps in wr_en; the counter does not advance.
- Exactly N/LANES writes occur per start.
- done occurs one cycle after the last wr_en.
- start asserted while busy=1, including the same cycle as done, is ignored. A new start is honoured in IDLE, the cycle after done.
- in_valid while in IDLE or FLUSH is ignored; nothing is consumed.
- rst_n low mid-polynomial: everything returns to reset values immediately. No further writes occur and no done is raised.

Decomposition:
- Package cbd_pkg holds: Q, COEFF_W, the legal ETA/LANES checks as elaboration-time assertions, and the FSM state encoding.
- One sub-module, cbd_lane: combinational popcount, subtract and mod-Q for one lane, parametrised by ETA.
- cbd_sampler instantiates LANES copies of cbd_lane plus the FSM, beat counter and output registers.

Test Plan:
- ETA=3, LANES=1, base_addr=0, in_valid held high, in_data = beat index[5:0] → 256 writes at addresses 0..255. Beat 0x07 (a=3, b=0) writes 3; beat 0x38 (a=0, b=3) writes 3326; beat 0x3F writes 0. done one cycle after write 255.
- ETA=2, LANES=4, base_addr=1020 → 64 writes with wr_addr 1020, 1021, 1022, 1023, 0, 1, … (wrap). Lane in_data 0xF writes 0; 0x3 writes 2; 0xC writes 3327.
- in_valid toggled 1,0,1,0 → wr_en follows one cycle later with matching gaps; total writes still N/LANES; data order preserved.
- start pulsed at beats 10 and 255 and in the done cycle → no restart; exactly one done; a start the cycle after done begins a new polynomial.
- rst_n low at beat 100 → all outputs 0 next cycle; no done; a subsequent start produces a full 256-write frame from base_addr.
- in_valid high while IDLE for 20 cycles → in_ready=0, wr_en=0 throughout.
